pe_ws_dbuf: RTL and testbench

- Weight-stationary systolic processing element, the parametrised successor of the single-weight WS PE.
- Generalises word and accumulator width and signedness, and adds double-buffered weights: a shadow register is loaded through a dedicated shift chain while the active weight keeps computing.
- Adds valid qualification, optional saturation and a sticky overflow flag.
- Tiles into an R x C array: activations flow horizontally, partial sums and weights flow vertically.

---
 rtl/pe_pkg.sv | 34 +++
 rtl/pe_mac_sat.sv | 65 ++++++
 rtl/pe_ws_dbuf.sv | 129 ++++++++++++
 tb/tb_pe_ws_dbuf.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared definitions for the weight-stationary double-buffered PE:
// command encodings and accumulator limit helper.
package pe_pkg;

  typedef enum logic [1:0] {
    PE_NOP   = 2'b00,
    PE_MAC   = 2'b01,
    PE_SWAP  = 2'b10,
    PE_FLUSH = 2'b11
  } pe_ctrl_e;

  // Widest accumulator the limit helper can describe.
  localparam int ACC_MAX_W = 128;

  // Largest (want_max = 1) or smallest (want_max = 0) value representable in
  // 'width' bits, as a zero-padded bit pattern.
  function automatic logic [ACC_MAX_W-1:0] acc_limit(
    input int   width,
    input logic is_signed,
    input logic want_max
  );
    logic [ACC_MAX_W-1:0] v;
    v = '0;
    for (int i = 0; i < ACC_MAX_W; i++) begin
      if (i < width - 1) begin
        v[i] = want_max;
      end else if (i == width - 1) begin
        v[i] = is_signed ? ~want_max : want_max;
      end
    end
    return v;
  endfunction

endpackage

// File: rtl/pe_mac_sat.sv
// Combinational multiply-accumulate: extends the product to the accumulator
// width, adds the incoming partial sum, flags overflow and optionally clamps.
module pe_mac_sat
  import pe_pkg::*;
#(
  parameter int WORD_WIDTH = 8,
  parameter int ACC_WIDTH  = 32,
  parameter int SIGNED     = 1,
  parameter int SATURATE   = 0
) (
  input  logic [WORD_WIDTH-1:0] i_a,
  input  logic [WORD_WIDTH-1:0] i_w,
  input  logic [ACC_WIDTH-1:0]  i_psum,
  output logic [ACC_WIDTH-1:0]  o_sum,
  output logic                  o_ovf
);

  localparam int PW = 2 * WORD_WIDTH;

  logic [PW-1:0]        w_prod;
  logic [ACC_WIDTH-1:0] w_ext;
  logic [ACC_WIDTH:0]   w_full;
  logic [ACC_WIDTH-1:0] w_raw;
  logic [ACC_WIDTH-1:0] w_max;
  logic [ACC_WIDTH-1:0] w_min;
  logic                 w_carry;
  logic                 w_sovf;
  logic                 w_ovf;

  generate
    if (SIGNED != 0) begin : g_signed
      logic signed [PW-1:0] w_as;
      logic signed [PW-1:0] w_ws;
      assign w_as   = PW'($signed(i_a));
      assign w_ws   = PW'($signed(i_w));
      assign w_prod = w_as * w_ws;
      assign w_ext  = ACC_WIDTH'($signed(w_prod));
    end else begin : g_unsigned
      assign w_prod = PW'(i_a) * PW'(i_w);
      assign w_ext  = ACC_WIDTH'(w_prod);
    end
  endgenerate

  assign w_full  = {1'b0, i_psum} + {1'b0, w_ext};
  assign w_raw   = w_full[ACC_WIDTH-1:0];
  assign w_carry = w_full[ACC_WIDTH];
  // Signed overflow: both addends agree in sign but the result does not.
  assign w_sovf  = (i_psum[ACC_WIDTH-1] == w_ext[ACC_WIDTH-1]) &&
                   (w_raw[ACC_WIDTH-1] != i_psum[ACC_WIDTH-1]);

  assign w_max = ACC_WIDTH'(acc_limit(ACC_WIDTH, SIGNED != 0, 1'b1));
  assign w_min = ACC_WIDTH'(acc_limit(ACC_WIDTH, SIGNED != 0, 1'b0));
  assign w_ovf = (SIGNED != 0) ? w_sovf : w_carry;

  always_comb begin
    o_sum = w_raw;
    o_ovf = w_ovf;
    // Overflow direction follows the sign of the partial sum when signed;
    // unsigned products are non-negative so only the top can be exceeded.
    if ((SATURATE != 0) && w_ovf) begin
      o_sum = ((SIGNED != 0) && i_psum[ACC_WIDTH-1]) ? w_min : w_max;
    end
  end

endmodule

// File: rtl/pe_ws_dbuf.sv
// Weight-stationary systolic PE with a shadow weight loaded over a shift
// chain, swapped into the active weight on command.
module pe_ws_dbuf
  import pe_pkg::*;
#(
  parameter int WORD_WIDTH = 8,
  parameter int ACC_WIDTH  = 32,
  parameter int SIGNED     = 1,
  parameter int SATURATE   = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            ctrl_in,
  output logic [1:0]            ctrl_out,
  input  logic [WORD_WIDTH-1:0] a_in,
  input  logic                  a_valid_in,
  output logic [WORD_WIDTH-1:0] a_out,
  output logic                  a_valid_out,
  input  logic [ACC_WIDTH-1:0]  psum_in,
  input  logic                  psum_valid_in,
  output logic [ACC_WIDTH-1:0]  psum_out,
  output logic                  psum_valid_out,
  input  logic [WORD_WIDTH-1:0] w_in,
  input  logic                  w_load_in,
  output logic [WORD_WIDTH-1:0] w_out,
  output logic                  w_load_out,
  output logic                  overflow
);

  logic [1:0]            r_ctrl;
  logic [WORD_WIDTH-1:0] r_a;
  logic                  r_a_valid;
  logic [ACC_WIDTH-1:0]  r_psum;
  logic                  r_psum_valid;
  logic [WORD_WIDTH-1:0] r_shadow;
  logic [WORD_WIDTH-1:0] r_active;
  logic                  r_overflow;

  logic [ACC_WIDTH-1:0]  w_sum;
  logic                  w_ovf;
  logic                  w_mac_fire;

  pe_mac_sat #(
    .WORD_WIDTH (WORD_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH),
    .SIGNED     (SIGNED),
    .SATURATE   (SATURATE)
  ) u_mac (
    .i_a    (a_in),
    .i_w    (r_active),
    .i_psum (psum_in),
    .o_sum  (w_sum),
    .o_ovf  (w_ovf)
  );

  assign w_mac_fire = (ctrl_in == PE_MAC) && a_valid_in && psum_valid_in;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ctrl    <= '0;
      r_a       <= '0;
      r_a_valid <= 1'b0;
    end else begin
      r_ctrl <= ctrl_in;
      if (ctrl_in == PE_FLUSH) begin
        r_a       <= '0;
        r_a_valid <= 1'b0;
      end else begin
        r_a       <= a_in;
        r_a_valid <= a_valid_in;
      end
    end
  end

  // Shadow shifts regardless of command; SWAP reads its pre-edge value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shadow <= '0;
      r_active <= '0;
    end else begin
      if (w_load_in) begin
        r_shadow <= w_in;
      end
      if (ctrl_in == PE_SWAP) begin
        r_active <= r_shadow;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_psum       <= '0;
      r_psum_valid <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_psum_valid <= 1'b0;
      case (ctrl_in)
        PE_MAC: begin
          if (w_mac_fire) begin
            r_psum       <= w_sum;
            r_psum_valid <= 1'b1;
            if (w_ovf) begin
              r_overflow <= 1'b1;
            end
          end
        end
        PE_SWAP: begin
          r_psum <= psum_in;
        end
        PE_FLUSH: begin
          r_psum     <= '0;
          r_overflow <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  assign ctrl_out       = r_ctrl;
  assign a_out          = r_a;
  assign a_valid_out    = r_a_valid;
  assign psum_out       = r_psum;
  assign psum_valid_out = r_psum_valid;
  assign w_out          = r_shadow;
  assign w_load_out     = w_load_in;
  assign overflow       = r_overflow;

endmodule

// File: tb/tb_pe_ws_dbuf.sv
// Bench for pe_ws_dbuf: a two-PE column for chain/swap behaviour plus three
// 16-bit variants (saturating, wrapping, unsigned) checked against a model.
module tb_pe_ws_dbuf;

  localparam logic [1:0] C_NOP   = 2'b00;
  localparam logic [1:0] C_MAC   = 2'b01;
  localparam logic [1:0] C_SWAP  = 2'b10;
  localparam logic [1:0] C_FLUSH = 2'b11;

  // clock / reset
  logic clk;
  logic reset;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec  = 0;
  int n_fail = 0;

  // two-PE column, 8/32 signed wrapping
  logic [1:0]  up_ctrl;
  logic [7:0]  up_a;
  logic        up_av;
  logic [7:0]  up_win;
  logic        up_wl;
  logic [7:0]  lo_a;
  logic        lo_av;
  logic [1:0]  up_ctrl_o, lo_ctrl_o;
  logic [7:0]  up_a_o, lo_a_o;
  logic        up_av_o, lo_av_o;
  logic [31:0] up_ps_o, lo_ps_o;
  logic        up_pv_o, lo_pv_o;
  logic [7:0]  up_w_o, lo_w_o;
  logic        up_wl_o, lo_wl_o;
  logic        up_ov, lo_ov;

  pe_ws_dbuf #(.WORD_WIDTH(8), .ACC_WIDTH(32), .SIGNED(1), .SATURATE(0)) u_up (
    .clk(clk), .reset(reset), .ctrl_in(up_ctrl), .ctrl_out(up_ctrl_o),
    .a_in(up_a), .a_valid_in(up_av), .a_out(up_a_o), .a_valid_out(up_av_o),
    .psum_in(32'd0), .psum_valid_in(1'b1), .psum_out(up_ps_o), .psum_valid_out(up_pv_o),
    .w_in(up_win), .w_load_in(up_wl), .w_out(up_w_o), .w_load_out(up_wl_o),
    .overflow(up_ov)
  );

  pe_ws_dbuf #(.WORD_WIDTH(8), .ACC_WIDTH(32), .SIGNED(1), .SATURATE(0)) u_lo (
    .clk(clk), .reset(reset), .ctrl_in(up_ctrl_o), .ctrl_out(lo_ctrl_o),
    .a_in(lo_a), .a_valid_in(lo_av), .a_out(lo_a_o), .a_valid_out(lo_av_o),
    .psum_in(up_ps_o), .psum_valid_in(up_pv_o), .psum_out(lo_ps_o), .psum_valid_out(lo_pv_o),
    .w_in(up_w_o), .w_load_in(up_wl_o), .w_out(lo_w_o), .w_load_out(lo_wl_o),
    .overflow(lo_ov)
  );

  // three 16-bit PEs sharing one stimulus
  logic [1:0]  t_ctrl;
  logic [7:0]  t_a;
  logic        t_av;
  logic [15:0] t_ps;
  logic        t_pv;
  logic [7:0]  t_win;
  logic        t_wl;
  logic [1:0]  sat_ctrl_o, wrp_ctrl_o, uns_ctrl_o;
  logic [7:0]  sat_a_o, wrp_a_o, uns_a_o;
  logic        sat_av_o, wrp_av_o, uns_av_o;
  logic [15:0] sat_ps, wrp_ps, uns_ps;
  logic        sat_pv, wrp_pv, uns_pv;
  logic [7:0]  sat_w_o, wrp_w_o, uns_w_o;
  logic        sat_wl_o, wrp_wl_o, uns_wl_o;
  logic        sat_ov, wrp_ov, uns_ov;

  pe_ws_dbuf #(.WORD_WIDTH(8), .ACC_WIDTH(16), .SIGNED(1), .SATURATE(1)) u_sat (
    .clk(clk), .reset(reset), .ctrl_in(t_ctrl), .ctrl_out(sat_ctrl_o),
    .a_in(t_a), .a_valid_in(t_av), .a_out(sat_a_o), .a_valid_out(sat_av_o),
    .psum_in(t_ps), .psum_valid_in(t_pv), .psum_out(sat_ps), .psum_valid_out(sat_pv),
    .w_in(t_win), .w_load_in(t_wl), .w_out(sat_w_o), .w_load_out(sat_wl_o),
    .overflow(sat_ov)
  );

  pe_ws_dbuf #(.WORD_WIDTH(8), .ACC_WIDTH(16), .SIGNED(1), .SATURATE(0)) u_wrp (
    .clk(clk), .reset(reset), .ctrl_in(t_ctrl), .ctrl_out(wrp_ctrl_o),
    .a_in(t_a), .a_valid_in(t_av), .a_out(wrp_a_o), .a_valid_out(wrp_av_o),
    .psum_in(t_ps), .psum_valid_in(t_pv), .psum_out(wrp_ps), .psum_valid_out(wrp_pv),
    .w_in(t_win), .w_load_in(t_wl), .w_out(wrp_w_o), .w_load_out(wrp_wl_o),
    .overflow(wrp_ov)
  );

  pe_ws_dbuf #(.WORD_WIDTH(8), .ACC_WIDTH(16), .SIGNED(0), .SATURATE(0)) u_uns (
    .clk(clk), .reset(reset), .ctrl_in(t_ctrl), .ctrl_out(uns_ctrl_o),
    .a_in(t_a), .a_valid_in(t_av), .a_out(uns_a_o), .a_valid_out(uns_av_o),
    .psum_in(t_ps), .psum_valid_in(t_pv), .psum_out(uns_ps), .psum_valid_out(uns_pv),
    .w_in(t_win), .w_load_in(t_wl), .w_out(uns_w_o), .w_load_out(uns_wl_o),
    .overflow(uns_ov)
  );

  // reference model state for the 16-bit trio
  logic [7:0]  m_shadow, m_active;
  logic [15:0] m_ps_s, m_ps_w, m_ps_u;
  logic        m_vld, m_ov_s, m_ov_w, m_ov_u;
  logic [1:0]  m_ctrl;
  logic [7:0]  m_a;
  logic        m_av;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle into the trio, advance the model by one command, compare.
  task automatic t_apply(input logic [1:0] c, input logic [7:0] a, input logic av,
                         input logic [15:0] p, input logic pv,
                         input logic [7:0] win, input logic wl);
    int prod_s, sum_s, sum_u;
    t_ctrl = c; t_a = a; t_av = av; t_ps = p; t_pv = pv; t_win = win; t_wl = wl;
    m_ctrl = c;
    m_a    = (c == C_FLUSH) ? 8'd0 : a;
    m_av   = (c == C_FLUSH) ? 1'b0 : av;
    m_vld  = 1'b0;
    case (c)
      C_MAC: begin
        if (av && pv) begin
          prod_s = int'($signed(a)) * int'($signed(m_active));
          sum_s  = int'($signed(p)) + prod_s;
          if (sum_s > 32767) begin
            m_ps_s = 16'h7FFF; m_ov_s = 1'b1; m_ov_w = 1'b1;
          end else if (sum_s < -32768) begin
            m_ps_s = 16'h8000; m_ov_s = 1'b1; m_ov_w = 1'b1;
          end else begin
            m_ps_s = sum_s[15:0];
          end
          m_ps_w = sum_s[15:0];
          sum_u  = int'(p) + int'(a) * int'(m_active);
          if (sum_u > 65535) m_ov_u = 1'b1;
          m_ps_u = sum_u[15:0];
          m_vld  = 1'b1;
        end
      end
      C_SWAP: begin
        m_active = m_shadow;
        m_ps_s = p; m_ps_w = p; m_ps_u = p;
      end
      C_FLUSH: begin
        m_ps_s = '0; m_ps_w = '0; m_ps_u = '0;
        m_ov_s = 1'b0; m_ov_w = 1'b0; m_ov_u = 1'b0;
      end
      default: begin
      end
    endcase
    if (wl) m_shadow = win;
    step();
    chk("sat_psum", sat_ps, m_ps_s);
    chk("wrp_psum", wrp_ps, m_ps_w);
    chk("uns_psum", uns_ps, m_ps_u);
    chk("sat_valid", sat_pv, m_vld);
    chk("uns_valid", uns_pv, m_vld);
    chk("sat_ovf", sat_ov, m_ov_s);
    chk("wrp_ovf", wrp_ov, m_ov_w);
    chk("uns_ovf", uns_ov, m_ov_u);
    chk("t_a_out", sat_a_o, m_a);
    chk("t_av_out", wrp_av_o, m_av);
    chk("t_ctrl_out", uns_ctrl_o, m_ctrl);
    chk("t_w_out", sat_w_o, m_shadow);
  endtask

  initial begin
    reset = 1'b0;
    up_ctrl = C_NOP; up_a = '0; up_av = 1'b0; up_win = '0; up_wl = 1'b0;
    lo_a = '0; lo_av = 1'b0;
    t_ctrl = C_NOP; t_a = '0; t_av = 1'b0; t_ps = '0; t_pv = 1'b0; t_win = '0; t_wl = 1'b0;
    m_shadow = '0; m_active = '0; m_ps_s = '0; m_ps_w = '0; m_ps_u = '0;
    m_vld = 1'b0; m_ov_s = 1'b0; m_ov_w = 1'b0; m_ov_u = 1'b0;
    m_ctrl = C_NOP; m_a = '0; m_av = 1'b0;

    // reset state
    #1 reset = 1'b1;
    #1;
    chk("rst_psum", up_ps_o, 32'd0);
    chk("rst_valid", up_pv_o, 1'b0);
    chk("rst_ctrl", up_ctrl_o, C_NOP);
    chk("rst_w_out", up_w_o, 8'd0);
    chk("rst_ovf", sat_ov, 1'b0);
    step();
    step();
    reset = 1'b0;
    step();

    // weight chain: push 3 then 4
    up_wl = 1'b1; up_win = 8'd3;
    step();
    chk("chain_up1", up_w_o, 8'd3);
    up_win = 8'd4;
    step();
    chk("chain_up2", up_w_o, 8'd4);
    chk("chain_lo2", lo_w_o, 8'd3);
    up_wl = 1'b0;

    // swap then MAC down the column
    up_ctrl = C_SWAP;
    step();
    chk("swap_ctrl_out", up_ctrl_o, C_SWAP);
    chk("swap_valid", up_pv_o, 1'b0);
    up_ctrl = C_MAC; up_a = 8'd2; up_av = 1'b1;
    step();
    chk("mac_up_psum", up_ps_o, 32'd8);
    chk("mac_up_valid", up_pv_o, 1'b1);
    up_ctrl = C_NOP; up_av = 1'b0; lo_a = 8'd3; lo_av = 1'b1;
    step();
    chk("mac_lo_psum", lo_ps_o, 32'd17);
    chk("mac_lo_valid", lo_pv_o, 1'b1);
    chk("nop_up_hold", up_ps_o, 32'd8);
    chk("nop_up_valid", up_pv_o, 1'b0);
    lo_av = 1'b0;

    // double buffer on the upper PE
    up_ctrl = C_MAC; up_a = 8'd2; up_av = 1'b1; up_wl = 1'b1; up_win = 8'd7;
    step();
    chk("dbuf_old_w", up_ps_o, 32'd8);
    chk("dbuf_shadow", up_w_o, 8'd7);
    up_wl = 1'b0; up_ctrl = C_SWAP; up_av = 1'b0;
    step();
    chk("dbuf_swap_psum", up_ps_o, 32'd0);
    up_ctrl = C_MAC; up_a = 8'd2; up_av = 1'b1;
    step();
    chk("dbuf_new_w", up_ps_o, 32'd14);
    up_ctrl = C_SWAP; up_wl = 1'b1; up_win = 8'd9; up_av = 1'b0;
    step();
    chk("swap_load_shadow", up_w_o, 8'd9);
    up_wl = 1'b0; up_ctrl = C_MAC; up_a = 8'd1; up_av = 1'b1;
    step();
    chk("swap_load_active", up_ps_o, 32'd7);

    // 16-bit arithmetic, directed
    t_apply(C_NOP, 8'd0, 1'b0, 16'd0, 1'b0, 8'd5, 1'b1);
    t_apply(C_SWAP, 8'd0, 1'b0, 16'd0, 1'b0, 8'd0, 1'b0);
    t_apply(C_MAC, 8'hFD, 1'b1, 16'd0, 1'b1, 8'd0, 1'b0);
    chk("neg_prod", sat_ps, 16'hFFF1);
    chk("uns_prod", uns_ps, 16'd1265);
    t_apply(C_NOP, 8'd0, 1'b0, 16'd0, 1'b0, 8'd10, 1'b1);
    t_apply(C_SWAP, 8'd0, 1'b0, 16'd0, 1'b0, 8'd0, 1'b0);
    t_apply(C_MAC, 8'd1, 1'b1, 16'd32760, 1'b1, 8'd0, 1'b0);
    chk("sat_clamp", sat_ps, 16'h7FFF);
    chk("sat_ovf_set", sat_ov, 1'b1);
    chk("wrap_val", wrp_ps, 16'h8002);
    chk("wrap_ovf_set", wrp_ov, 1'b1);
    t_apply(C_FLUSH, 8'd5, 1'b1, 16'd0, 1'b1, 8'd0, 1'b0);
    chk("flush_psum", sat_ps, 16'd0);
    chk("flush_ovf", sat_ov, 1'b0);
    chk("flush_valid", sat_pv, 1'b0);
    t_apply(C_MAC, 8'd1, 1'b1, 16'd0, 1'b1, 8'd0, 1'b0);
    chk("flush_keep_w", sat_ps, 16'd10);

    // randomized commands against the model
    for (int i = 0; i < 300; i++) begin
      logic [1:0] c;
      int r;
      r = $urandom_range(0, 9);
      c = (r < 6) ? C_MAC : (r == 6) ? C_NOP : (r == 7) ? C_SWAP : (r == 8) ? C_FLUSH : C_MAC;
      t_apply(c, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 3) != 0),
              16'($urandom_range(0, 65535)), 1'($urandom_range(0, 3) != 0),
              8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    end

    // mid-cycle reset during MAC traffic
    up_ctrl = C_MAC; up_a = 8'd2; up_av = 1'b1;
    step();
    chk("pre_rst_psum", up_ps_o, 32'd14);
    #2 reset = 1'b1;
    #1;
    chk("midrst_psum", up_ps_o, 32'd0);
    chk("midrst_valid", up_pv_o, 1'b0);
    chk("midrst_ctrl", up_ctrl_o, C_NOP);
    chk("midrst_a", up_a_o, 8'd0);
    chk("midrst_av", up_av_o, 1'b0);
    chk("midrst_w", up_w_o, 8'd0);
    chk("midrst_lo_w", lo_w_o, 8'd0);
    chk("midrst_t_psum", wrp_ps, 16'd0);
    @(negedge clk);
    reset = 1'b0;
    up_ctrl = C_SWAP; up_av = 1'b0;
    #1;
    chk("post_rst_ctrl0", up_ctrl_o, C_NOP);
    step();
    chk("post_rst_ctrl1", up_ctrl_o, C_SWAP);
    up_ctrl = C_MAC; up_av = 1'b1;
    step();
    chk("post_rst_ctrl2", up_ctrl_o, C_MAC);
    chk("post_rst_w0", up_ps_o, 32'd0);
    chk("post_rst_valid", up_pv_o, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
